// File: rtl/croc_pkg.sv
// Shared SoC constants for the interrupt controller: register map offsets,
// default line count and the decoded register selector.
package croc_pkg;

    localparam int unsigned IrqCtrlNumIrqDefault = 16;

    localparam logic [3:0] IrqCtrlPendingOffset = 4'h0;
    localparam logic [3:0] IrqCtrlEnableOffset  = 4'h4;
    localparam logic [3:0] IrqCtrlModeOffset    = 4'h8;
    localparam logic [3:0] IrqCtrlStatusOffset  = 4'hC;

    typedef enum logic [2:0] {
        RegPending,
        RegEnable,
        RegMode,
        RegStatus,
        RegNone
    } irq_reg_e;

    // Unaligned offsets never decode to a register.
    function automatic irq_reg_e decodeReg(input logic [3:0] addr);
        irq_reg_e sel;
        case (addr)
            IrqCtrlPendingOffset: sel = RegPending;
            IrqCtrlEnableOffset:  sel = RegEnable;
            IrqCtrlModeOffset:    sel = RegMode;
            IrqCtrlStatusOffset:  sel = RegStatus;
            default:              sel = RegNone;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// OBI-style register bus between the core-side master and the interrupt controller.
interface irq_ctrl_if;

    logic        req_i;
    logic        we_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic        err_o;
    logic [31:0] rdata_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o
    );

endinterface

// File: rtl/irq_sync.sv
// Two-flop synchronizer applied bitwise to a vector of asynchronous interrupt sources.
module irq_sync #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] r_meta;
    logic [Width-1:0] r_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-line edge/level capture, enable masking, OBI register access.
// Optional IRQ_CTRL_SYNC_EN inserts a 2-flop synchronizer on irq_src_i.
module irq_ctrl
    import croc_pkg::*;
#(
    parameter int unsigned NumIrq = IrqCtrlNumIrqDefault
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] irq_src_i,
    irq_ctrl_if.slave   bus,
    output logic [15:0] irqs_o
);

    localparam logic [15:0] ValidMask = 16'((32'd1 << NumIrq) - 32'd1);

    logic [15:0] w_src;
    logic [15:0] w_srcSampled;
    logic [15:0] r_s;
    logic [15:0] r_sPrev;
    logic [15:0] r_pending;
    logic [15:0] r_enable;
    logic [15:0] r_mode;
    logic [15:0] w_pendingNext;
    logic [15:0] w_wdata;
    logic [15:0] w_edge;
    logic [15:0] w_w1c;
    logic [15:0] w_regRead;
    logic        w_aligned;
    logic        w_wrEn;
    irq_reg_e    w_sel;
    logic        r_rvalid;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        w_unusedWdata;

    assign w_src         = irq_src_i & ValidMask;
    assign w_wdata       = bus.wdata_i[15:0] & ValidMask;
    assign w_unusedWdata = ^bus.wdata_i[31:16];
    assign w_aligned     = (bus.addr_i[1:0] == 2'b00);
    assign w_sel         = decodeReg(bus.addr_i);
    assign w_wrEn        = bus.req_i & bus.we_i & w_aligned;

`ifdef IRQ_CTRL_SYNC_EN
    irq_sync #(
        .Width(16)
    ) u_irq_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_d    (w_src),
        .o_q    (w_srcSampled)
    );
`else
    assign w_srcSampled = w_src;
`endif

    always_comb begin
        w_regRead = '0;
        case (w_sel)
            RegPending: w_regRead = r_pending;
            RegEnable:  w_regRead = r_enable;
            RegMode:    w_regRead = r_mode;
            RegStatus:  w_regRead = r_pending & r_enable;
            default:    w_regRead = '0;
        endcase
    end

    // A new edge beats a same-cycle W1C; a MODE write drops any line whose mode flips.
    always_comb begin
        w_edge        = r_s & ~r_sPrev;
        w_w1c         = (w_wrEn && w_sel == RegPending) ? w_wdata : '0;
        w_pendingNext = (r_mode & ((r_pending & ~w_w1c) | w_edge)) | (~r_mode & r_s);
        if (w_wrEn && w_sel == RegMode) begin
            w_pendingNext = w_pendingNext & ~(r_mode ^ w_wdata);
        end
        w_pendingNext = w_pendingNext & ValidMask;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s       <= '0;
            r_sPrev   <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_mode    <= '0;
        end else begin
            r_s       <= w_srcSampled;
            r_sPrev   <= r_s;
            r_pending <= w_pendingNext;
            if (w_wrEn && w_sel == RegEnable) begin
                r_enable <= w_wdata;
            end
            if (w_wrEn && w_sel == RegMode) begin
                r_mode <= w_wdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= bus.req_i;
            r_err    <= bus.req_i & ~w_aligned;
            if (bus.req_i) begin
                r_rdata <= {16'h0000, w_regRead};
            end
        end
    end

    assign bus.gnt_o    = bus.req_i;
    assign bus.rvalid_o = r_rvalid;
    assign bus.err_o    = r_err;
    assign bus.rdata_o  = r_rdata;
    assign irqs_o       = r_pending & r_enable;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic against
// a per-line behavioural model of the interrupt rules.
module tb_irq_ctrl;
    import croc_pkg::*;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int SrcDelay = 2;
`else
    localparam int SrcDelay = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] irqSrc;
    logic [15:0] irqs;

    irq_ctrl_if bus ();

    irq_ctrl #(
        .NumIrq(16)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .irq_src_i (irqSrc),
        .bus       (bus),
        .irqs_o    (irqs)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] mPending, mEnable, mMode;
    logic [15:0] srcHist [0:3];
    logic        expValid, expErr;
    logic [31:0] expRdata;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPending = '0;
        mEnable  = '0;
        mMode    = '0;
        expValid = 1'b0;
        expErr   = 1'b0;
        expRdata = '0;
        for (int k = 0; k < 4; k++) srcHist[k] = '0;
    endtask

    // One clock edge of the reference: response from old state, then per-line rules.
    task automatic modelEdge(input logic req, input logic we, input logic [3:0] addr,
                             input logic [31:0] wdata, input logic [15:0] src);
        logic [15:0] oldS, oldSPrev, nextPending, wd;
        bit aligned, doW1c, doMode;
        oldS     = srcHist[SrcDelay];
        oldSPrev = srcHist[SrcDelay + 1];
        aligned  = (addr % 4) == 0;
        wd       = wdata[15:0];
        expValid = req;
        expErr   = req && !aligned;
        expRdata = 0;
        if (req && aligned) begin
            if (addr == 4'd0)       expRdata = {16'd0, mPending};
            else if (addr == 4'd4)  expRdata = {16'd0, mEnable};
            else if (addr == 4'd8)  expRdata = {16'd0, mMode};
            else                    expRdata = {16'd0, mPending & mEnable};
        end
        doW1c  = req && we && aligned && addr == 4'd0;
        doMode = req && we && aligned && addr == 4'd8;
        for (int i = 0; i < 16; i++) begin
            if (mMode[i]) begin
                nextPending[i] = (oldS[i] && !oldSPrev[i]) || (mPending[i] && !(doW1c && wd[i]));
            end else begin
                nextPending[i] = oldS[i];
            end
            if (doMode && (wd[i] != mMode[i])) nextPending[i] = 1'b0;
        end
        mPending = nextPending;
        if (req && we && aligned && addr == 4'd4) mEnable = wd;
        if (doMode) mMode = wd;
        for (int k = 3; k > 0; k--) srcHist[k] = srcHist[k - 1];
        srcHist[0] = src;
    endtask

    // Drive one cycle from a falling edge, then check everything at the next falling edge.
    task automatic applyStimulus(input logic req, input logic we, input logic [3:0] addr,
                                 input logic [31:0] wdata, input logic [15:0] src);
        bus.req_i   = req;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        irqSrc      = src;
        #1;
        checkOutput("gnt", {31'd0, bus.gnt_o}, {31'd0, req});
        modelEdge(req, we, addr, wdata, src);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rvalid", {31'd0, bus.rvalid_o}, {31'd0, expValid});
        checkOutput("err", {31'd0, bus.err_o}, {31'd0, expErr});
        if (expValid) checkOutput("rdata", bus.rdata_o, expRdata);
        checkOutput("irqs", {16'd0, irqs}, {16'd0, mPending & mEnable});
    endtask

    task automatic idle(input logic [15:0] src);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, src);
    endtask

    initial begin
        logic [15:0] src;
        logic [3:0]  addr;
        int firstHigh, highCount;

        rst_n = 1'b0;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
        irqSrc = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("rst_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        checkOutput("rst_irqs", {16'd0, irqs}, 32'd0);
        checkOutput("rst_rdata", bus.rdata_o, 32'd0);
        rst_n = 1'b1;

        // Reset state readback
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b1, 1'b0, 4'(r * 4), 32'h0, 16'h0);
            checkOutput("rst_read", bus.rdata_o, 32'd0);
        end

        // Edge line 0: latency and W1C
        applyStimulus(1'b1, 1'b1, IrqCtrlEnableOffset, 32'h1, 16'h0);
        applyStimulus(1'b1, 1'b1, IrqCtrlModeOffset, 32'h1, 16'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h1);
        firstHigh = -1;
        for (int k = 0; k < 8; k++) begin
            idle(16'h0);
            if (irqs[0] && firstHigh < 0) firstHigh = k;
        end
        checkOutput("edge_latency", firstHigh, SrcDelay);
        checkOutput("edge_held", {31'd0, irqs[0]}, 32'd1);
        applyStimulus(1'b1, 1'b1, IrqCtrlPendingOffset, 32'h1, 16'h0);
        checkOutput("edge_w1c", {31'd0, irqs[0]}, 32'd0);

        // Level line 3: W1C while high has no effect
        applyStimulus(1'b1, 1'b1, IrqCtrlEnableOffset, 32'h9, 16'h0);
        highCount = 0;
        for (int k = 0; k < 12; k++) begin
            src = (k < 5) ? 16'h8 : 16'h0;
            if (k == 3) applyStimulus(1'b1, 1'b1, IrqCtrlPendingOffset, 32'h8, src);
            else        idle(src);
            if (irqs[3]) highCount++;
        end
        checkOutput("level_width", highCount, 5);

        // Edge line 5: same-cycle W1C loses to a new edge
        applyStimulus(1'b1, 1'b1, IrqCtrlModeOffset, 32'h21, 16'h0);
        applyStimulus(1'b1, 1'b1, IrqCtrlEnableOffset, 32'h29, 16'h0);
        idle(16'h20);
        for (int k = 0; k < SrcDelay; k++) idle(16'h20);
        applyStimulus(1'b1, 1'b1, IrqCtrlPendingOffset, 32'h20, 16'h20);
        checkOutput("set_wins", {31'd0, irqs[5]}, 32'd1);
        applyStimulus(1'b1, 1'b1, IrqCtrlPendingOffset, 32'h20, 16'h20);
        checkOutput("w1c_no_edge", {31'd0, irqs[5]}, 32'd0);

        // Unaligned access
        applyStimulus(1'b1, 1'b1, 4'h2, 32'hFFFF, 16'h0);
        checkOutput("unaligned_err", {31'd0, bus.err_o}, 32'd1);
        checkOutput("unaligned_rdata", bus.rdata_o, 32'd0);
        applyStimulus(1'b1, 1'b0, IrqCtrlEnableOffset, 32'h0, 16'h0);
        checkOutput("unaligned_nochg", bus.rdata_o, 32'h29);

        // Back-to-back write then STATUS read
        applyStimulus(1'b1, 1'b1, IrqCtrlModeOffset, 32'h0, 16'h0110);
        applyStimulus(1'b1, 1'b1, IrqCtrlEnableOffset, 32'h0, 16'h0110);
        for (int k = 0; k < 4; k++) idle(16'h0110);
        applyStimulus(1'b1, 1'b1, IrqCtrlEnableOffset, 32'hFFFF, 16'h0110);
        checkOutput("b2b_wr_valid", {31'd0, bus.rvalid_o}, 32'd1);
        applyStimulus(1'b1, 1'b0, IrqCtrlStatusOffset, 32'h0, 16'h0110);
        checkOutput("b2b_rd_valid", {31'd0, bus.rvalid_o}, 32'd1);
        checkOutput("b2b_status", bus.rdata_o, 32'h0110);

        // Random traffic
        src = 16'h0;
        for (int n = 0; n < 1500; n++) begin
            src = src ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            addr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : {2'($urandom), 2'b00};
            applyStimulus(1'($urandom), 1'($urandom), addr, $urandom, src);
        end

        // Request in flight when reset asserts is dropped
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = IrqCtrlEnableOffset; bus.wdata_i = 32'hFFFF;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_irqs", {16'd0, irqs}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_i = 1'b0;
        irqSrc    = 16'h0;
        rst_n     = 1'b1;
        modelReset();
        @(posedge clk);
        @(negedge clk);
        checkOutput("drop_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        applyStimulus(1'b1, 1'b0, IrqCtrlEnableOffset, 32'h0, 16'h0);
        checkOutput("drop_enable", bus.rdata_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NumIrq, default 16, number of interrupt lines (1..16); bits above NumIrq read 0 and are never asserted.
REQ-002 SHALL have port clk_i  input  1  single clock.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port irq_src_i  input  16  raw peripheral interrupt sources, active-high.
REQ-005 SHALL have ports req_i/we_i  input  1/1  OBI-style register request and write flag.
REQ-006 SHALL have ports addr_i  input  4  byte offset (word-aligned); wdata_i  input  32  write data.
REQ-007 SHALL have ports gnt_o/rvalid_o/err_o  output  1/1/1  grant, response valid, response error.
REQ-008 SHALL have port rdata_o  output  32  read data.
REQ-009 SHALL have port irqs_o  output  16  masked interrupts, wired directly to the core's irq_fast_i.

Function
REQ-010 SHALL grant every request in the same cycle (gnt_o = req_i).
REQ-011 SHALL assert rvalid_o exactly one cycle after each granted request, with rdata_o/err_o registered; back-to-back requests SHALL each get one response.
REQ-012 SHALL map registers: 0x0 PENDING (read; write-1-to-clear), 0x4 ENABLE (RW), 0x8 MODE (RW, 1=edge, 0=level), 0xC STATUS (RO, = PENDING & ENABLE).
REQ-013 SHALL respond to an unaligned (addr_i[1:0]!=0) access with err_o=1, rdata_o=0, no state change; writes to STATUS SHALL be ignored without error.
REQ-014 SHALL register irq_src_i into sample vector s each cycle and keep s_prev = previous s.
REQ-015 Edge mode: pending[i] SHALL set when s[i] & ~s_prev[i]; SHALL stay set until cleared by W1C.
REQ-016 Level mode: pending[i] SHALL follow s[i] every cycle; W1C SHALL have no effect.
REQ-017 Simultaneous W1C and new edge on the same bit in the same cycle: set SHALL win.
REQ-018 Writing MODE SHALL clear pending bits whose mode changes; s_prev SHALL be unaffected.
REQ-019 irqs_o SHALL equal pending & ENABLE combinationally from flops; no extra pipeline.
REQ-020 Latency without sync: source rising in cycle N SHALL appear on irqs_o in cycle N+2.
REQ-021 Enable-bit set while pending already set SHALL assert irqs_o in the cycle after the write response is issued.

Reset
REQ-022 On rst_ni low, asynchronously: PENDING, ENABLE, MODE, s, s_prev, synchronizer flops = 0; rvalid_o, err_o = 0; rdata_o = 0; irqs_o = 0.
REQ-023 A request in flight when reset asserts SHALL be dropped; no rvalid_o after reset release.

Configuration
REQ-024 Macro IRQ_CTRL_SYNC_EN: when defined, each irq_src_i bit SHALL pass a 2-flop synchronizer before s, making REQ-020 latency N+4; when undefined, sources SHALL be treated as synchronous to clk_i (latency N+2).

Structure
REQ-025 Register offsets (IrqCtrlPendingOffset, ...EnableOffset, ...ModeOffset, ...StatusOffset) and NumIrq default SHALL live in croc_pkg.
REQ-026 Synchronizer SHALL be one sub-module, irq_sync, instantiated per-vector only under IRQ_CTRL_SYNC_EN.

Verification
REQ-027 Reset release, read all four registers -> rdata 0x0, err_o=0, irqs_o=0.
REQ-028 ENABLE=0x0001, MODE=0x0001, pulse irq_src_i[0] one cycle at N -> irqs_o[0]=1 at N+2 (N+4 with sync) and stays 1; W1C 0x1 to PENDING -> irqs_o[0]=0 next cycle.
REQ-029 Level mode bit 3 enabled, hold irq_src_i[3] high 5 cycles -> irqs_o[3] high 5 cycles delayed 2; W1C during high -> no change.
REQ-030 Edge bit 5: W1C to PENDING in the same cycle a new edge is sampled -> pending[5] remains 1.
REQ-031 Read from 0x2 -> rvalid_o next cycle, err_o=1, rdata 0; registers unchanged.
REQ-032 Back-to-back write ENABLE=0xFFFF then read STATUS with pending=0x0110 -> responses in consecutive cycles, read returns 0x0110.
